// File: rtl/rr_decode_arbiter8.sv
// Eight-requester round-robin arbiter. It produces a one-hot grant in 3x8 decoder
// encoding and a binary owner index, and it can force a release after a hold timeout.
module rr_decode_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q;
  logic [2:0]        ptr_q;
  logic [2:0]        idx_q;
  logic [7:0]        grant_q;
  logic              valid_q;
  logic              timeout_q;
  logic [HOLD_W-1:0] hold_q;

  logic [2:0]        winner_d;
  logic              arb_go_d;
  logic              rel_done_d;
  logic              rel_drop_d;
  logic              rel_hold_d;
  logic              release_d;
  logic [HOLD_W-1:0] hold_inc_d;

  // The first requester at or after ptr wins; the search wraps from 7 back to 0.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] cand;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = p + 3'(k);
      if (!found && r[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [7:0] dec3to8(input logic [2:0] idx);
    dec3to8 = 8'b0000_0001 << idx;
  endfunction

  always_comb begin
    winner_d   = rr_pick(req, ptr_q);
    arb_go_d   = en && (req != 8'h00);
    rel_done_d = done;
    rel_drop_d = !req[idx_q];
    rel_hold_d = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));
    release_d  = rel_done_d || rel_drop_d || rel_hold_d;
    hold_inc_d = (&hold_q) ? hold_q : hold_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      idx_q     <= 3'd0;
      grant_q   <= 8'h00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_go_d) begin
            state_q <= GRANT;
            idx_q   <= winner_d;
            grant_q <= dec3to8(winner_d);
            valid_q <= 1'b1;
            hold_q  <= HOLD_W'(1);
          end
        end
        GRANT: begin
          if (release_d) begin
            // Release always takes priority; the next arbitration runs from the rotated pointer.
            state_q   <= IDLE;
            grant_q   <= 8'h00;
            valid_q   <= 1'b0;
            ptr_q     <= idx_q + 3'd1;
            timeout_q <= rel_hold_d && !rel_done_d && !rel_drop_d;
          end else begin
            hold_q <= hold_inc_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter8.sv
// Directed bench for rr_decode_arbiter8. It checks reset, the single-owner grant,
// the round-robin rotation, hold timeout, owner drop, en gating and async reset.
module tb_rr_decode_arbiter8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  rr_decode_arbiter8 #(.MAX_HOLD(16), .HOLD_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                         input logic v, input logic to);
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".idx"}, {5'd0, grant_idx}, {5'd0, idx});
    chk({tag, ".valid"}, {7'd0, grant_valid}, {7'd0, v});
    chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, to});
  endtask

  // Structural invariants sampled on the falling edge of every cycle.
  always @(negedge clk) begin
    chk("inv_onehot", {7'd0, ((grant & (grant - 8'd1)) == 8'h00)}, 8'd1);
    chk("inv_valid", {7'd0, grant_valid}, {7'd0, |grant});
    if (grant_valid)
      chk("inv_idx", grant, 8'h01 << grant_idx);
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] exp_idx;

    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    tick();
    tick();
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // The arbiter is out of reset but en is low, so no grant may appear.
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("en_low.grant", grant, 8'h00);
    end

    // A single requester is granted on the first edge, and done releases it.
    en  = 1'b1;
    req = 8'h10;
    tick();
    chk_out("single.g", 8'h10, 3'd4, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("single.hold", 8'h10, 3'd4, 1'b1, 1'b0);
    done = 1'b1;
    req  = 8'h21;
    tick();
    done = 1'b0;
    chk_out("single.rel", 8'h00, 3'd4, 1'b0, 1'b0);
    tick();
    chk_out("ptr5", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_out("drop5", 8'h00, 3'd5, 1'b0, 1'b0);
    tick();
    chk("idle_noreq.grant", grant, 8'h00);

    // With every request held, the pointer is 6 and grants rotate through 7 and wrap to 0.
    req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      exp_idx = 3'(6 + i);
      tick();
      chk_out($sformatf("rr%0d.g", i), 8'h01 << exp_idx, exp_idx, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_out($sformatf("rr%0d.rel", i), 8'h00, exp_idx, 1'b0, 1'b0);
    end

    // Timeout: the pointer is 0 and the grant is forced off after exactly 16 visible cycles.
    req = 8'h03;
    tick();
    chk_out("to.g", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("to.hold%0d", i), grant, 8'h01);
      chk($sformatf("to.nopulse%0d", i), {7'd0, timeout}, 8'd0);
    end
    tick();
    chk_out("to.rel", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    chk_out("to.next", 8'h02, 3'd1, 1'b1, 1'b0);

    // done arriving on the timeout edge still releases, but with no timeout pulse.
    for (int i = 0; i < 15; i++) tick();
    chk("to2.hold", grant, 8'h02);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_out("to2.done_rel", 8'h00, 3'd1, 1'b0, 1'b0);

    // The owner drops its request on the same edge that a new request rises.
    req = 8'h04;
    tick();
    chk_out("drop.g", 8'h04, 3'd2, 1'b1, 1'b0);
    tick();
    req = 8'h40;
    tick();
    chk_out("drop.rel", 8'h00, 3'd2, 1'b0, 1'b0);
    tick();
    chk_out("drop.next", 8'h40, 3'd6, 1'b1, 1'b0);

    // Pulling rst_n low between edges clears the grant without a clock edge.
    req = 8'h00;
    tick();
    req = 8'h08;
    tick();
    chk_out("ar.g", 8'h08, 3'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar.async", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    req   = 8'h09;
    rst_n = 1'b1;
    tick();
    chk_out("ar.after", 8'h01, 3'd0, 1'b1, 1'b0);

    // When en falls during a grant, the grant completes normally and then no new grant is issued.
    en   = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("en_fall.rel", grant, 8'h00);
    tick();
    tick();
    chk("en_fall.idle", grant, 8'h00);
    en = 1'b1;
    tick();
    chk_out("en_rise", 8'h08, 3'd3, 1'b1, 1'b0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
